// File: rtl/hm_rx.sv
// hm_rx: receive side of the host-memory read path. Accepts CplD TLPs for our tag/requester ID,
// realigns the 3DW-header payload into 64-bit buffer words and tracks split completions.
module hm_rx #(
    parameter logic [7:0]  TAG     = 8'h38,
    parameter int unsigned LEN_DW  = 32,
    parameter logic [15:0] TIMEOUT = 16'hffff
) (
    input  logic        trn_clk,
    input  logic        sys_rst,
    input  logic        rx_start,
    output logic        rx_end,
    output logic        rx_err,
    output logic        timeout,
    input  logic [63:0] trn_rd,
    input  logic        trn_rsof_n,
    input  logic        trn_reof_n,
    input  logic        trn_rrem_n,
    input  logic        trn_rsrc_rdy_n,
    output logic        trn_rdst_rdy_n,
    input  logic        trn_rsrc_dsc_n,
    output logic [63:0] hm_wdata,
    output logic [4:0]  hm_waddr,
    output logic        hm_we,
    input  logic [7:0]  cfg_bus_number,
    input  logic [4:0]  cfg_device_number,
    input  logic [2:0]  cfg_function_number,
    output logic [31:0] stat_trn_cpt_rx,
    output logic [31:0] stat_trn_cpt_drop,
    output logic [2:0]  stat_state
);
    localparam int unsigned CW = 7;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT    = 3'd1,
        S_HDR2    = 3'd2,
        S_DATA    = 3'd3,
        S_DISCARD = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] dw_cpt_q, dw_cpt_d, end_dw_q, end_dw_d;
    logic [31:0]   held_q, held_d;
    logic          hdr_ok_q, hdr_ok_d, disc_err_q, disc_err_d, disc_armed_q, disc_armed_d;
    logic [15:0]   timer_q, timer_d;
    logic [31:0]   cpt_rx_q, cpt_rx_d, cpt_drop_q, cpt_drop_d;
    logic          rx_end_q, rx_end_d, rx_err_q, rx_err_d, timeout_q, timeout_d;
    logic          we_q, we_d, rdst_rdy_n_q;
    logic [63:0]   wdata_q, wdata_d;
    logic [4:0]    waddr_q, waddr_d;

    logic          beat, sof, eof, dsc, is_cpld, id_ok, hdr_ok_c, armed, tmo_hit, drop_inc;
    logic [9:0]    len_c;
    logic [15:0]   req_id;
    logic [CW-1:0] dw_next;

    assign beat     = !trn_rsrc_rdy_n && !rdst_rdy_n_q;
    assign sof      = beat && !trn_rsof_n;
    assign eof      = beat && !trn_reof_n;
    assign dsc      = beat && !trn_rsrc_dsc_n;
    assign req_id   = {cfg_bus_number, cfg_device_number, cfg_function_number};
    assign len_c    = trn_rd[41:32];
    assign is_cpld  = (trn_rd[63:61] == 3'b010) && (trn_rd[60:56] == 5'b01010);
    assign id_ok    = (trn_rd[63:48] == req_id) && (trn_rd[47:40] == TAG);
    assign hdr_ok_c = (trn_rd[15:13] == 3'b000) && (len_c != 10'd0) && !len_c[0] &&
                      ({1'b0, len_c} <= (11'(LEN_DW) - 11'(dw_cpt_q)));
    assign dw_next  = dw_cpt_q + CW'(2);
    // Timer only runs while a request is outstanding; an unarmed discard must not time out.
    assign armed    = (state_q == S_WAIT) || (state_q == S_HDR2) || (state_q == S_DATA) ||
                      ((state_q == S_DISCARD) && disc_armed_q);
    assign tmo_hit  = armed && ((17'(timer_q) + 17'd1) == {1'b0, TIMEOUT});

    always_comb begin
        state_d      = state_q;
        dw_cpt_d     = dw_cpt_q;
        end_dw_d     = end_dw_q;
        held_d       = held_q;
        hdr_ok_d     = hdr_ok_q;
        disc_err_d   = disc_err_q;
        disc_armed_d = disc_armed_q;
        timer_d      = armed ? timer_q + 16'd1 : timer_q;
        cpt_rx_d     = cpt_rx_q;
        drop_inc     = 1'b0;
        rx_end_d     = 1'b0;
        rx_err_d     = 1'b0;
        timeout_d    = 1'b0;
        we_d         = 1'b0;
        wdata_d      = wdata_q;
        waddr_d      = waddr_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (state_q == S_IDLE && rx_start) begin
                    state_d  = S_WAIT;
                    timer_d  = 16'd0;
                    dw_cpt_d = '0;
                end
                if (sof) begin
                    if (eof || dsc) begin
                        drop_inc = 1'b1;
                    end else begin
                        disc_armed_d = (state_q == S_IDLE) && rx_start;
                        disc_err_d   = 1'b0;
                        state_d      = S_DISCARD;
                    end
                end
            end
            S_WAIT: begin
                if (sof) begin
                    if (is_cpld && !eof && !dsc) begin
                        state_d  = S_HDR2;
                        hdr_ok_d = hdr_ok_c;
                        end_dw_d = CW'(11'(dw_cpt_q) + 11'(len_c));
                    end else if (eof || dsc) begin
                        drop_inc = 1'b1;
                    end else begin
                        state_d      = S_DISCARD;
                        disc_err_d   = 1'b0;
                        disc_armed_d = 1'b1;
                    end
                end
            end
            S_HDR2: begin
                if (beat) begin
                    if (!id_ok) begin
                        if (eof || dsc) begin
                            drop_inc = 1'b1;
                            state_d  = S_WAIT;
                        end else begin
                            state_d      = S_DISCARD;
                            disc_err_d   = 1'b0;
                            disc_armed_d = 1'b1;
                        end
                    end else if (dsc || eof) begin
                        state_d  = S_IDLE;
                        rx_end_d = 1'b1;
                        rx_err_d = 1'b1;
                    end else if (!hdr_ok_q) begin
                        state_d      = S_DISCARD;
                        disc_err_d   = 1'b1;
                        disc_armed_d = 1'b1;
                    end else begin
                        state_d = S_DATA;
                        held_d  = trn_rd[31:0];
                    end
                end
            end
            S_DATA: begin
                if (dsc) begin
                    state_d  = S_IDLE;
                    rx_end_d = 1'b1;
                    rx_err_d = 1'b1;
                end else if (beat) begin
                    // Held DW from the previous beat pairs with the upper DW of this one.
                    we_d     = 1'b1;
                    wdata_d  = {held_q, trn_rd[63:32]};
                    waddr_d  = dw_cpt_q[5:1];
                    dw_cpt_d = dw_next;
                    held_d   = trn_rd[31:0];
                    if (eof) begin
                        if (!trn_rrem_n || dw_next != end_dw_q) begin
                            state_d  = S_IDLE;
                            rx_end_d = 1'b1;
                            rx_err_d = 1'b1;
                        end else if (dw_next == CW'(LEN_DW)) begin
                            state_d  = S_DONE;
                            rx_end_d = 1'b1;
                            cpt_rx_d = cpt_rx_q + 32'd1;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end
                end
            end
            S_DISCARD: begin
                if (eof || dsc) begin
                    if (disc_err_q) begin
                        state_d  = S_IDLE;
                        rx_end_d = 1'b1;
                        rx_err_d = 1'b1;
                    end else begin
                        drop_inc = 1'b1;
                        state_d  = disc_armed_q ? S_WAIT : S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Timeout yields to any end already decided this cycle; a TLP in flight is drained unarmed.
        if (tmo_hit && !rx_end_d) begin
            rx_end_d  = 1'b1;
            timeout_d = 1'b1;
            we_d      = 1'b0;
            if (state_d == S_HDR2 || state_d == S_DATA || state_d == S_DISCARD) begin
                state_d      = S_DISCARD;
                disc_err_d   = 1'b0;
                disc_armed_d = 1'b0;
            end else begin
                state_d = S_IDLE;
            end
        end

        cpt_drop_d = cpt_drop_q + 32'(drop_inc);
    end

    always_ff @(posedge trn_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= S_IDLE;
            dw_cpt_q     <= '0;
            end_dw_q     <= '0;
            held_q       <= '0;
            hdr_ok_q     <= 1'b0;
            disc_err_q   <= 1'b0;
            disc_armed_q <= 1'b0;
            timer_q      <= '0;
            cpt_rx_q     <= '0;
            cpt_drop_q   <= '0;
            rx_end_q     <= 1'b0;
            rx_err_q     <= 1'b0;
            timeout_q    <= 1'b0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            waddr_q      <= '0;
            rdst_rdy_n_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            dw_cpt_q     <= dw_cpt_d;
            end_dw_q     <= end_dw_d;
            held_q       <= held_d;
            hdr_ok_q     <= hdr_ok_d;
            disc_err_q   <= disc_err_d;
            disc_armed_q <= disc_armed_d;
            timer_q      <= timer_d;
            cpt_rx_q     <= cpt_rx_d;
            cpt_drop_q   <= cpt_drop_d;
            rx_end_q     <= rx_end_d;
            rx_err_q     <= rx_err_d;
            timeout_q    <= timeout_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            waddr_q      <= waddr_d;
            rdst_rdy_n_q <= 1'b0;
        end
    end

    assign rx_end            = rx_end_q;
    assign rx_err            = rx_err_q;
    assign timeout           = timeout_q;
    assign trn_rdst_rdy_n    = rdst_rdy_n_q;
    assign hm_wdata          = wdata_q;
    assign hm_waddr          = waddr_q;
    assign hm_we             = we_q;
    assign stat_trn_cpt_rx   = cpt_rx_q;
    assign stat_trn_cpt_drop = cpt_drop_q;
    assign stat_state        = state_q;
endmodule
